// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - requester and ram_1x4 bank signals of ram_arbiter
// slave = arbiter side, master = requesters plus the bank's data_out bus.
interface ram_arbiter_if #(
    parameter int WORDS = 4,
    parameter int AW    = 2
);
    logic             a_req;
    logic             a_rw;
    logic [AW-1:0]    a_addr;
    logic [3:0]       a_wdata;
    logic             a_ack;
    logic             b_req;
    logic             b_rw;
    logic [AW-1:0]    b_addr;
    logic [3:0]       b_wdata;
    logic             b_ack;
    logic [3:0]       rdata;
    logic             err;
    logic [WORDS-1:0] ram_sel;
    logic             ram_rw;
    logic [3:0]       ram_din;
    logic [3:0]       ram_dout;
    logic             ram_clr;

    modport slave (
        input  a_req, a_rw, a_addr, a_wdata,
        input  b_req, b_rw, b_addr, b_wdata,
        input  ram_dout,
        output a_ack, b_ack, rdata, err,
        output ram_sel, ram_rw, ram_din, ram_clr
    );

    modport master (
        output a_req, a_rw, a_addr, a_wdata,
        output b_req, b_rw, b_addr, b_wdata,
        output ram_dout,
        input  a_ack, b_ack, rdata, err,
        input  ram_sel, ram_rw, ram_din, ram_clr
    );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester arbiter/sequencer for a ram_1x4 word bank
// RAM_ARB_FIXED_PRIO_EN: A always wins ties (no round-robin pointer).
module ram_arbiter #(
    parameter int WORDS = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          clr_n,
    ram_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {INIT, IDLE, ACCESS, DONE} state_t;

    localparam logic [AW:0] LIMIT = (AW+1)'(WORDS);

    state_t           state_q, state_d;
    logic             cmd_rw_q, cmd_rw_d;
    logic [AW-1:0]    cmd_addr_q, cmd_addr_d;
    logic             who_q, who_d;          // 0 = A granted, 1 = B granted
    logic [WORDS-1:0] sel_q, sel_d;
    logic             rw_q, rw_d;
    logic [3:0]       din_q, din_d;
    logic             clr_q, clr_d;
    logic             a_ack_q, a_ack_d;
    logic             b_ack_q, b_ack_d;
    logic [3:0]       rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             grant_a, grant_b;
    logic             g_rw;
    logic [AW-1:0]    g_addr;
    logic [3:0]       g_wdata;
    logic             in_range;

`ifndef RAM_ARB_FIXED_PRIO_EN
    logic             ptr_q, ptr_d;          // 0 = favour A, 1 = favour B
`endif

    function automatic logic [WORDS-1:0] decode(input logic [AW-1:0] addr);
        logic [WORDS-1:0] oh;
        oh = '0;
        for (int i = 0; i < WORDS; i++) begin
            oh[i] = (addr == AW'(i));
        end
        return oh;
    endfunction

    always_comb begin
`ifdef RAM_ARB_FIXED_PRIO_EN
        grant_a = bus.a_req;
`else
        grant_a = bus.a_req & (~bus.b_req | ~ptr_q);
`endif
        grant_b = bus.b_req & ~grant_a;
        g_rw    = grant_b ? bus.b_rw    : bus.a_rw;
        g_addr  = grant_b ? bus.b_addr  : bus.a_addr;
        g_wdata = grant_b ? bus.b_wdata : bus.a_wdata;
    end

    assign in_range = ({1'b0, cmd_addr_q} < LIMIT);

    always_comb begin
        state_d    = state_q;
        cmd_rw_d   = cmd_rw_q;
        cmd_addr_d = cmd_addr_q;
        who_d      = who_q;
`ifndef RAM_ARB_FIXED_PRIO_EN
        ptr_d      = ptr_q;
`endif
        sel_d      = '0;
        rw_d       = 1'b0;
        din_d      = 4'h0;
        clr_d      = 1'b0;
        a_ack_d    = 1'b0;
        b_ack_d    = 1'b0;
        rdata_d    = rdata_q;
        err_d      = err_q;

        case (state_q)
            INIT: begin
                state_d = IDLE;
            end
            IDLE: begin
                if (grant_a | grant_b) begin
                    cmd_rw_d   = g_rw;
                    cmd_addr_d = g_addr;
                    who_d      = grant_b;
`ifndef RAM_ARB_FIXED_PRIO_EN
                    ptr_d      = grant_a;
`endif
                    // bank drive for ACCESS is registered here so outputs stay glitch-free
                    sel_d      = decode(g_addr);
                    rw_d       = g_rw;
                    din_d      = g_rw ? g_wdata : 4'h0;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                err_d = ~in_range;
                if (!in_range) begin
                    rdata_d = 4'h0;
                end else if (!cmd_rw_q) begin
                    rdata_d = bus.ram_dout;
                end
                a_ack_d = ~who_q;
                b_ack_d = who_q;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= INIT;
            cmd_rw_q   <= 1'b0;
            cmd_addr_q <= '0;
            who_q      <= 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
            ptr_q      <= 1'b0;
`endif
            sel_q      <= '0;
            rw_q       <= 1'b0;
            din_q      <= 4'h0;
            clr_q      <= 1'b1;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            rdata_q    <= 4'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_rw_q   <= cmd_rw_d;
            cmd_addr_q <= cmd_addr_d;
            who_q      <= who_d;
`ifndef RAM_ARB_FIXED_PRIO_EN
            ptr_q      <= ptr_d;
`endif
            sel_q      <= sel_d;
            rw_q       <= rw_d;
            din_q      <= din_d;
            clr_q      <= clr_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign bus.ram_sel = sel_q;
    assign bus.ram_rw  = rw_q;
    assign bus.ram_din = din_q;
    assign bus.ram_clr = clr_q;
    assign bus.a_ack   = a_ack_q;
    assign bus.b_ack   = b_ack_q;
    assign bus.rdata   = rdata_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed bench for ram_arbiter (WORDS=4 and WORDS=3 in lockstep)
// Both instances see the same requests; each drives its own ram_1x4 bank model.
module tb_ram_arbiter;
`ifdef RAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr_n;
    logic       a_req, a_rw, b_req, b_rw;
    logic [1:0] a_addr, b_addr;
    logic [3:0] a_wdata, b_wdata;

    always #5 clk = ~clk;

    ram_arbiter_if #(.WORDS(4), .AW(2)) i1 ();
    ram_arbiter_if #(.WORDS(3), .AW(2)) i2 ();

    ram_arbiter #(.WORDS(4), .AW(2)) dut1 (.clk(clk), .clr_n(clr_n), .bus(i1.slave));
    ram_arbiter #(.WORDS(3), .AW(2)) dut2 (.clk(clk), .clr_n(clr_n), .bus(i2.slave));

    assign i1.a_req = a_req;   assign i2.a_req = a_req;
    assign i1.a_rw = a_rw;     assign i2.a_rw = a_rw;
    assign i1.a_addr = a_addr; assign i2.a_addr = a_addr;
    assign i1.a_wdata = a_wdata; assign i2.a_wdata = a_wdata;
    assign i1.b_req = b_req;   assign i2.b_req = b_req;
    assign i1.b_rw = b_rw;     assign i2.b_rw = b_rw;
    assign i1.b_addr = b_addr; assign i2.b_addr = b_addr;
    assign i1.b_wdata = b_wdata; assign i2.b_wdata = b_wdata;

    // ram_1x4 bank models: clr wipes, selected cell writes on rw=1, drives data_out on rw=0
    logic [3:0] m1 [4];
    logic [3:0] m2 [3];
    logic [3:0] d1, d2;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i1.ram_clr) m1[i] <= 4'h0;
            else if (i1.ram_sel[i] && i1.ram_rw) m1[i] <= i1.ram_din;
        end
        for (int i = 0; i < 3; i++) begin
            if (i2.ram_clr) m2[i] <= 4'h0;
            else if (i2.ram_sel[i] && i2.ram_rw) m2[i] <= i2.ram_din;
        end
    end

    always_comb begin
        d1 = 4'bzzzz;
        d2 = 4'bzzzz;
        for (int i = 0; i < 4; i++) if (i1.ram_sel[i] && !i1.ram_rw) d1 = m1[i];
        for (int i = 0; i < 3; i++) if (i2.ram_sel[i] && !i2.ram_rw) d2 = m2[i];
    end
    assign i1.ram_dout = d1;
    assign i2.ram_dout = d2;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    logic [3:0] sel1_acc;
    logic [2:0] sel2_acc;
    logic       ack2, err2;
    logic [3:0] rd2;

    // one access from IDLE; returns ack latency in cycles and leaves the DUT in IDLE
    task automatic xfer(input string tag, input bit side, input bit rw, input logic [1:0] addr,
                        input logic [3:0] wd, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        if (!side) begin a_req = 1'b1; a_rw = rw; a_addr = addr; a_wdata = wd; end
        else       begin b_req = 1'b1; b_rw = rw; b_addr = addr; b_wdata = wd; end
        for (int i = 1; i <= 8 && !seen; i++) begin
            @(negedge clk);
            if (i == 1) begin sel1_acc = i1.ram_sel; sel2_acc = i2.ram_sel; end
            if (side ? i1.b_ack : i1.a_ack) begin
                seen = 1'b1;
                lat  = i;
                ack2 = side ? i2.b_ack : i2.a_ack;
                err2 = i2.err;
                rd2  = i2.rdata;
            end
        end
        chk({tag, "_ack_seen"}, seen, 1);
        a_req = 1'b0;
        b_req = 1'b0;
        @(negedge clk);
    endtask

    int lat, n_ack;
    int who_q[$];
    int cyc_q[$];

    initial begin
        #200000;
        $display("FAIL watchdog got running exp finished");
        $fatal(1);
    end

    initial begin
        a_req = 0; a_rw = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_rw = 0; b_addr = 0; b_wdata = 0;
        clr_n = 1'b1;
        #2 clr_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_clr", i1.ram_clr, 1);
        chk("rst_sel", i1.ram_sel, 0);
        chk("rst_rw_din", {i1.ram_rw, i1.ram_din}, 0);
        chk("rst_acks", {i1.a_ack, i1.b_ack}, 0);
        chk("rst_rdata_err", {i1.rdata, i1.err}, 0);
        clr_n = 1'b1;
        chk("clr_hold", i1.ram_clr, 1);
        @(negedge clk);
        chk("clr_drop", i1.ram_clr, 0);

        // A writes 0xA to word 2, cycle by cycle
        a_req = 1; a_rw = 1; a_addr = 2; a_wdata = 4'hA;
        @(negedge clk);
        chk("wr_sel", i1.ram_sel, 4'b0100);
        chk("wr_rw", i1.ram_rw, 1);
        chk("wr_din", i1.ram_din, 4'hA);
        chk("wr_noack_yet", i1.a_ack, 0);
        @(negedge clk);
        chk("wr_ack", i1.a_ack, 1);
        chk("wr_done_sel", {i1.ram_sel, i1.ram_rw}, 0);
        chk("wr_err", i1.err, 0);
        chk("wr_cell", m1[2], 4'hA);
        a_req = 0;
        @(negedge clk);
        chk("wr_ack_pulse", i1.a_ack, 0);

        xfer("rd_b", 1, 0, 2, 0, lat);
        chk("rd_b_lat", lat, 2);
        chk("rd_b_rdata", i1.rdata, 4'hA);
        chk("rd_b_err", i1.err, 0);

        // both requesters hold requests continuously
        a_req = 1; a_rw = 0; a_addr = 2;
        b_req = 1; b_rw = 0; b_addr = 2;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (i1.a_ack) begin who_q.push_back(0); cyc_q.push_back(i); end
            if (i1.b_ack) begin who_q.push_back(1); cyc_q.push_back(i); end
        end
        a_req = 0; b_req = 0;
        @(negedge clk);
        chk("rr_count", who_q.size(), 4);
        for (int k = 0; k < 4 && k < who_q.size(); k++) begin
            chk($sformatf("rr_who%0d", k), who_q[k], FIXED ? 0 : (k % 2));
            chk($sformatf("rr_cyc%0d", k), cyc_q[k], 2 + 3 * k);
        end

        // word 3: out of range on the WORDS=3 instance
        xfer("oor", 0, 1, 3, 4'h7, lat);
        chk("oor_sel2", sel2_acc, 3'b000);
        chk("oor_sel1", sel1_acc, 4'b1000);
        chk("oor_ack2", ack2, 1);
        chk("oor_err2", err2, 1);
        chk("oor_rd2", rd2, 4'h0);
        chk("oor_cells2", {m2[2], m2[1], m2[0]}, 12'hA00);
        chk("oor_err1", i1.err, 0);
        xfer("inr", 0, 0, 2, 0, lat);
        chk("inr_err2", err2, 0);
        chk("inr_rd2", rd2, 4'hA);

        for (int w = 0; w < 4; w++) xfer("fill", 0, 1, w[1:0], 4'hF, lat);
        chk("fill_cells", {m1[3], m1[2], m1[1], m1[0]}, 16'hFFFF);
        clr_n = 1'b0;
        #1 chk("rc_clr_now", i1.ram_clr, 1);
        @(negedge clk);
        clr_n = 1'b1;
        chk("rc_clr_hold", i1.ram_clr, 1);
        @(negedge clk);
        chk("rc_clr_drop", i1.ram_clr, 0);
        for (int w = 0; w < 4; w++) begin
            xfer("rc_rd", 0, 0, w[1:0], 0, lat);
            chk($sformatf("rc_word%0d", w), i1.rdata, 4'h0);
        end

        // reset lands in the ACCESS cycle of a write of 0x5 to word 1
        xfer("mid_pre_wr", 0, 1, 1, 4'h9, lat);
        xfer("mid_pre_rd", 1, 0, 1, 0, lat);
        chk("mid_pre_rdata", i1.rdata, 4'h9);
        a_req = 1; a_rw = 1; a_addr = 1; a_wdata = 4'h5;
        @(negedge clk);
        chk("mid_access_sel", i1.ram_sel, 4'b0010);
        clr_n = 1'b0;
        #1;
        chk("mid_sel", {i1.ram_sel, i1.ram_rw, i1.ram_din}, 0);
        chk("mid_clr", i1.ram_clr, 1);
        chk("mid_rdata_err", {i1.rdata, i1.err}, 0);
        a_req = 0;
        n_ack = 0;
        @(negedge clk);
        clr_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i1.a_ack || i1.b_ack) n_ack++;
            @(negedge clk);
        end
        chk("mid_no_ack", n_ack, 0);
        xfer("mid_rd", 0, 0, 1, 0, lat);
        chk("mid_rd_val", i1.rdata, 4'h0);

        // A holds its request through the ack: a second read follows 3 cycles later
        xfer("hold_wr", 0, 1, 0, 4'h3, lat);
        a_req = 1; a_rw = 0; a_addr = 0;
        @(negedge clk);
        @(negedge clk);
        chk("hold_ack1", i1.a_ack, 1);
        chk("hold_rd1", i1.rdata, 4'h3);
        @(negedge clk);
        chk("hold_gap1", {i1.a_ack, i1.b_ack, i1.err, i1.rdata}, 7'h03);
        @(negedge clk);
        chk("hold_gap2", {i1.a_ack, i1.b_ack, i1.err, i1.rdata}, 7'h03);
        @(negedge clk);
        chk("hold_ack2", {i1.a_ack, i1.b_ack}, 2'b10);
        chk("hold_rd2", i1.rdata, 4'h3);
        a_req = 0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
